square_wave_meas: RTL and testbench



---
 rtl/sqw_meas_pkg.sv | 28 ++
 rtl/sqw_meas_sync_edge.sv | 54 +++++
 rtl/square_wave_meas.sv | 200 ++++++++++++++++++++
 tb/tb_square_wave_meas.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqw_meas_pkg.sv
// Shared constants for the square-wave measurement block and its generator bench.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sqw_meas_pkg;

  // Measurement FSM state encoding
  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  typedef enum logic [1:0] {
    S_ARM  = ST_ARM,
    S_HIGH = ST_HIGH,
    S_LOW  = ST_LOW
  } meas_state_e;

  // Default sizing, shared with the generator bench
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 1000;

  // Number of cycles after reset during which edges are ignored while the
  // synchroniser fills up from its reset value.
  function automatic int unsigned blank_cycles(input int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/sqw_meas_sync_edge.sv
// Synchronises the asynchronous square wave and produces single-cycle rise/fall pulses.
// Latency: sig_s follows sig_in after SYNC_STAGES clk edges; rise/fall are combinational from sig_s.
// Backpressure: none; free-running, independent of enable.
module sqw_sync_edge
  import sqw_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  localparam int unsigned BLANK = blank_cycles(SYNC_STAGES);
  localparam int unsigned BW    = $clog2(BLANK + 1);
  localparam logic [BW-1:0] BLANK_V = BW'(BLANK);
  localparam logic [BW-1:0] BONE    = {{(BW-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sig_dly_q, sig_dly_d;
  logic [BW-1:0]          blank_q, blank_d;
  logic                   edge_ok;

  assign sig_s   = sync_q[SYNC_STAGES-1];
  // Edges are only trusted once the chain has fully refilled after reset, so a
  // level held through reset never looks like a transition.
  assign edge_ok = (blank_q == BLANK_V);
  assign rise    = edge_ok &  sig_s & ~sig_dly_q;
  assign fall    = edge_ok & ~sig_s &  sig_dly_q;

  // Next-state: shift the chain, delay sig_s, count out the blanking window
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    sig_dly_d = sig_s;
    blank_d   = edge_ok ? blank_q : blank_q + BONE;
  end

  // Synchroniser and blanking registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sig_dly_q <= 1'b0;
      blank_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      sig_dly_q <= sig_dly_d;
      blank_q   <= blank_d;
    end
  end

endmodule

// File: rtl/square_wave_meas.sv
// Measures high time, low time and period of an async square wave; flags a stuck input.
// Latency: meas_valid strobes SYNC_STAGES+1 clk edges after the closing rising edge is first sampled.
// Backpressure: none; each published result is a one-cycle strobe with held data.
module square_wave_meas
  import sqw_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             ovf,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  logic sig_s, rise, fall, any_edge;

  sqw_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .sig_s (sig_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign any_edge = rise | fall;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0] lo_acc_q, lo_acc_d;
  logic             hi_sat_q, hi_sat_d;
  logic             lo_sat_q, lo_sat_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;
  logic             meas_vld_q, meas_vld_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] hi_inc, lo_inc;
  logic             timeout;

  // Saturating increments; the counters never wrap back to small values
  assign hi_inc = (hi_acc_q == CNT_MAX) ? CNT_MAX : hi_acc_q + ONE;
  assign lo_inc = (lo_acc_q == CNT_MAX) ? CNT_MAX : lo_acc_q + ONE;

  // Next-state: enable gating, idle timeout, phase FSM and publish
  always_comb begin
    state_d     = state_q;
    hi_acc_d    = hi_acc_q;
    lo_acc_d    = lo_acc_q;
    hi_sat_d    = hi_sat_q;
    lo_sat_d    = lo_sat_q;
    idle_d      = idle_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    meas_vld_d  = 1'b0;
    high_d      = high_q;
    low_d       = low_q;
    period_d    = period_q;
    ovf_d       = ovf_q;
    timeout     = 1'b0;

    if (!en) begin
      // Disabled: drop any partial measurement but keep the last published result
      state_d     = S_ARM;
      hi_acc_d    = '0;
      lo_acc_d    = '0;
      hi_sat_d    = 1'b0;
      lo_sat_d    = 1'b0;
      idle_d      = '0;
      stuck_d     = 1'b0;
      stuck_lvl_d = 1'b0;
    end else begin
      // Idle tracking: any edge restarts it, and an edge always beats a timeout
      // landing in the same cycle. Once stuck, the count parks until the next edge.
      if (any_edge) begin
        idle_d      = '0;
        stuck_d     = 1'b0;
        stuck_lvl_d = 1'b0;
      end else if (!stuck_q) begin
        idle_d  = idle_q + ONE;
        timeout = (idle_d == TIMEOUT_V);
      end

      case (state_q)
        S_ARM: begin
          // Only a rise starts a measurement; a fall here has no phase to close
          if (rise) begin
            state_d  = S_HIGH;
            hi_acc_d = ONE;
            lo_acc_d = '0;
            hi_sat_d = 1'b0;
            lo_sat_d = 1'b0;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state_d  = S_LOW;
            lo_acc_d = ONE;
          end else begin
            // A count sitting at full scale is indistinguishable from overflow
            hi_acc_d = hi_inc;
            hi_sat_d = hi_sat_q | (hi_inc == CNT_MAX);
          end
        end
        S_LOW: begin
          if (rise) begin
            meas_vld_d = 1'b1;
            high_d     = hi_acc_q;
            low_d      = lo_acc_q;
            period_d   = {1'b0, hi_acc_q} + {1'b0, lo_acc_q};
            ovf_d      = hi_sat_q | lo_sat_q;
            state_d    = S_HIGH;
            hi_acc_d   = ONE;
            lo_acc_d   = '0;
            hi_sat_d   = 1'b0;
            lo_sat_d   = 1'b0;
          end else begin
            lo_acc_d = lo_inc;
            lo_sat_d = lo_sat_q | (lo_inc == CNT_MAX);
          end
        end
        default: begin
          state_d = S_ARM;
        end
      endcase

      // Stuck input: abandon the measurement and record the level it froze at
      if (timeout) begin
        state_d     = S_ARM;
        hi_acc_d    = '0;
        lo_acc_d    = '0;
        hi_sat_d    = 1'b0;
        lo_sat_d    = 1'b0;
        stuck_d     = 1'b1;
        stuck_lvl_d = sig_s;
      end
    end
  end

  // State, accumulators and published results, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ARM;
      hi_acc_q    <= '0;
      lo_acc_q    <= '0;
      hi_sat_q    <= 1'b0;
      lo_sat_q    <= 1'b0;
      idle_q      <= '0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      meas_vld_q  <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      period_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_acc_q    <= hi_acc_d;
      lo_acc_q    <= lo_acc_d;
      hi_sat_q    <= hi_sat_d;
      lo_sat_q    <= lo_sat_d;
      idle_q      <= idle_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      meas_vld_q  <= meas_vld_d;
      high_q      <= high_d;
      low_q       <= low_d;
      period_q    <= period_d;
      ovf_q       <= ovf_d;
    end
  end

  assign meas_valid  = meas_vld_q;
  assign high_cnt    = high_q;
  assign low_cnt     = low_q;
  assign period_cnt  = period_q;
  assign ovf         = ovf_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_square_wave_meas.sv
// Bench for square_wave_meas: table rows, hand sequences for corner cases, random waveform vs model.
// Latency: sig_in is driven per clk cycle; results checked at the falling edge.
// Backpressure: none.
module tb_square_wave_meas;

  localparam int SYNC = 2;
  localparam int TO   = 20;
  localparam int TO4  = 15;
  localparam int NW   = 920;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sig_in = 1'b0;

  logic        mv, ov, st, sl;
  logic [15:0] hc, lc;
  logic [16:0] pc;
  logic        mv4, ov4, st4, sl4;
  logic [3:0]  hc4, lc4;
  logic [4:0]  pc4;

  square_wave_meas #(.CNT_W(16), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .meas_valid(mv), .high_cnt(hc), .low_cnt(lc), .period_cnt(pc),
    .ovf(ov), .stuck(st), .stuck_level(sl)
  );

  square_wave_meas #(.CNT_W(4), .SYNC_STAGES(SYNC), .TIMEOUT(TO4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .meas_valid(mv4), .high_cnt(hc4), .low_cnt(lc4), .period_cnt(pc4),
    .ovf(ov4), .stuck(st4), .stuck_level(sl4)
  );

  always #5 clk = ~clk;

  typedef struct {int h; int l; int p; int o;} meas_t;
  typedef struct {int h; int l; bit use4; int eh; int el; int ep; int eo;} vec_t;

  int    tests = 0;
  int    fails = 0;
  int    vld_n = 0;
  int    vld4_n = 0;
  meas_t q[$];
  meas_t q4[$];

  logic  wave [0:NW-1];
  bit    exp_v [0:NW-1];
  int    exp_h [0:NW-1];
  int    exp_l [0:NW-1];
  int    rises[$];
  int    falls[$];
  vec_t  tbl [0:8];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_meas(input string name, input meas_t m, input int h, input int l,
                            input int p, input int o);
    check({name, "_high"}, m.h, h);
    check({name, "_low"}, m.l, l);
    check({name, "_period"}, m.p, p);
    check({name, "_ovf"}, m.o, o);
  endtask

  function automatic meas_t pick(input bit use4, input int idx);
    meas_t bad;
    bad = '{-1, -1, -1, -1};
    if (!use4 && idx >= 0 && idx < q.size()) return q[idx];
    if (use4 && idx >= 0 && idx < q4.size()) return q4[idx];
    return bad;
  endfunction

  // Record any strobe seen in the current cycle
  task automatic observe();
    if (mv) begin
      vld_n++;
      q.push_back('{int'(hc), int'(lc), int'(pc), int'(ov)});
    end
    if (mv4) begin
      vld4_n++;
      q4.push_back('{int'(hc4), int'(lc4), int'(pc4), int'(ov4)});
    end
  endtask

  // Each call covers n cycles: look at the cycle, then set sig_in for it
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      observe();
      sig_in = v;
    end
  endtask

  task automatic pattern(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic clear_log();
    q.delete();
    q4.delete();
    vld_n  = 0;
    vld4_n = 0;
  endtask

  task automatic do_reset(input logic lvl, input string name);
    @(negedge clk);
    sig_in = lvl;
    en     = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check({name, "_rst_outputs"}, {mv, hc, lc, pc, ov, st, sl}, 0);
    check({name, "_rst_outputs4"}, {mv4, hc4, lc4, pc4, ov4, st4, sl4}, 0);
    rst_n = 1'b1;
    clear_log();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int    len, h, l, idx, w0, w1;
    meas_t m;

    tbl[0] = '{5,  5, 1'b0, 5,  5, 10, 0};
    tbl[1] = '{3,  7, 1'b0, 3,  7, 10, 0};
    tbl[2] = '{12, 4, 1'b0, 12, 4, 16, 0};
    tbl[3] = '{4,  4, 1'b0, 4,  4, 8,  0};
    tbl[4] = '{1,  1, 1'b0, 1,  1, 2,  0};
    tbl[5] = '{20, 4, 1'b0, 20, 4, 24, 0};  // fall lands on the timeout cycle
    tbl[6] = '{15, 3, 1'b1, 15, 3, 18, 1};  // count reaches full scale
    tbl[7] = '{14, 2, 1'b1, 14, 2, 16, 0};
    tbl[8] = '{5,  5, 1'b1, 5,  5, 10, 0};

    // Level held high through reset must not count as a rise
    do_reset(1'b1, "hold_high");
    drive(1'b1, 10);
    check("hold_high_no_valid", vld_n, 0);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 5);
    check("hold_high_valid_count", vld_n, 1);
    check_meas("hold_high", pick(1'b0, 0), 5, 5, 10, 0);

    // Reset pulsed in the middle of a high phase
    drive(1'b1, 5);
    drive(1'b1, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_high_rst_outputs", {mv, hc, lc, pc, ov, st, sl}, 0);
    rst_n = 1'b1;
    clear_log();
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 5);
    check("mid_high_no_stale_publish", vld_n, 0);
    check("mid_high_held_zero", hc, 0);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 4);
    check("mid_high_valid_count", vld_n, 1);
    check_meas("mid_high", pick(1'b0, 0), 5, 5, 10, 0);

    // Table rows: three full periods from ARM give exactly two results
    for (int i = 0; i < 9; i++) begin
      do_reset(1'b0, $sformatf("row%0d", i));
      drive(1'b0, 6);
      pattern(tbl[i].h, tbl[i].l, 3);
      drive(1'b0, 4);
      check($sformatf("row%0d_count", i), tbl[i].use4 ? vld4_n : vld_n, 2);
      check_meas($sformatf("row%0d", i), pick(tbl[i].use4, 1),
                 tbl[i].eh, tbl[i].el, tbl[i].ep, tbl[i].eo);
    end

    // Duty change mid-stream: every result is one whole old or new period
    do_reset(1'b0, "switch");
    drive(1'b0, 6);
    pattern(3, 7, 3);
    pattern(12, 4, 3);
    drive(1'b0, 4);
    check("switch_count", vld_n, 5);
    for (int i = 0; i < 3; i++) check_meas($sformatf("switch_a%0d", i), pick(1'b0, i), 3, 7, 10, 0);
    for (int i = 3; i < 5; i++) check_meas($sformatf("switch_b%0d", i), pick(1'b0, i), 12, 4, 16, 0);

    // Saturated period followed by a normal one clears ovf
    do_reset(1'b0, "sat");
    drive(1'b0, 6);
    pattern(15, 3, 2);
    pattern(5, 5, 2);
    drive(1'b0, 4);
    check("sat_count", vld4_n, 3);
    check_meas("sat_a", pick(1'b1, 0), 15, 3, 18, 1);
    check_meas("sat_b", pick(1'b1, 1), 15, 3, 18, 1);
    check_meas("sat_c", pick(1'b1, 2), 5, 5, 10, 0);

    // Stuck high: asserts TIMEOUT clocks after the synchronised rise is registered
    do_reset(1'b0, "stuck");
    drive(1'b0, 6);
    pattern(4, 4, 1);
    @(negedge clk);
    observe();
    sig_in = 1'b1;
    for (int j = 1; j <= TO + SYNC + 1; j++) begin
      @(negedge clk);
      observe();
      if (j == TO + SYNC) check("stuck_not_yet", st, 0);
      if (j == TO + SYNC + 1) begin
        check("stuck_set", st, 1);
        check("stuck_level_set", sl, 1);
      end
    end
    drive(1'b1, 5);
    check("stuck_holds", st, 1);
    clear_log();
    @(negedge clk);
    observe();
    sig_in = 1'b0;
    for (int j = 1; j <= SYNC + 1; j++) begin
      @(negedge clk);
      observe();
      if (j == SYNC) check("stuck_before_edge", st, 1);
      if (j == SYNC + 1) begin
        check("stuck_cleared", st, 0);
        check("stuck_level_cleared", sl, 0);
      end
    end
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    check("stuck_recover_count", vld_n, 1);
    check_meas("stuck_recover", pick(1'b0, 0), 4, 4, 8, 0);

    // Enable dropped during a low phase
    do_reset(1'b0, "enable");
    drive(1'b0, 6);
    pattern(5, 5, 3);
    drive(1'b1, 5);
    drive(1'b0, 2);
    check("en_pre_count", vld_n, 3);
    en = 1'b0;
    w0 = vld_n;
    drive(1'b0, 3);
    check("en_low_no_valid", vld_n, w0);
    check("en_low_hold_high", hc, 5);
    check("en_low_hold_period", pc, 10);
    en = 1'b1;
    w1 = vld_n;
    drive(1'b0, 3);
    drive(1'b1, 6);
    drive(1'b0, 6);
    check("en_first_rise_no_valid", vld_n, w1);
    drive(1'b1, 6);
    drive(1'b0, 6);
    check("en_after_count", vld_n, w1 + 1);
    check_meas("en_after", pick(1'b0, vld_n - 1), 6, 6, 12, 0);

    // Random waveform against a run-length model of the input
    do_reset(1'b0, "rnd");
    drive(1'b0, 6);
    for (int c = 0; c < NW; c++) begin
      wave[c]  = 1'b0;
      exp_v[c] = 1'b0;
      exp_h[c] = 0;
      exp_l[c] = 0;
    end
    len = 8;
    while (len < 860) begin
      h = int'($urandom_range(15, 1));
      l = int'($urandom_range(15, 1));
      for (int k = 0; k < h; k++) begin wave[len] = 1'b1; len++; end
      for (int k = 0; k < l; k++) begin wave[len] = 1'b0; len++; end
    end
    rises.delete();
    falls.delete();
    for (int c = 1; c < len; c++) begin
      if (wave[c] && !wave[c-1]) rises.push_back(c);
      if (!wave[c] && wave[c-1]) falls.push_back(c);
    end
    // Every rise after the first closes one period; its result strobes
    // SYNC+1 cycles after the rise is driven.
    for (int k = 1; k < rises.size(); k++) begin
      idx        = rises[k] + SYNC + 1;
      exp_v[idx] = 1'b1;
      exp_h[idx] = falls[k-1] - rises[k-1];
      exp_l[idx] = rises[k] - falls[k-1];
    end
    for (int c = 0; c < len + SYNC + 2; c++) begin
      @(negedge clk);
      check($sformatf("rnd_valid_c%0d", c), mv, exp_v[c]);
      if (exp_v[c]) begin
        check($sformatf("rnd_high_c%0d", c), hc, exp_h[c]);
        check($sformatf("rnd_low_c%0d", c), lc, exp_l[c]);
        check($sformatf("rnd_period_c%0d", c), pc, exp_h[c] + exp_l[c]);
        check($sformatf("rnd_ovf_c%0d", c), ov, 0);
      end
      sig_in = wave[c];
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
